// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/write-back over
// a shared ALU and memory, stalling on the memory ready handshake.
module multicycle_ctrl (
  input logic             clk,
  input logic             rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StFetch    = 4'd1;
  localparam logic [3:0] StDecode   = 4'd2;
  localparam logic [3:0] StMemAddr  = 4'd3;
  localparam logic [3:0] StMemRd    = 4'd4;
  localparam logic [3:0] StMemWb    = 4'd5;
  localparam logic [3:0] StMemWr    = 4'd6;
  localparam logic [3:0] StRExec    = 4'd7;
  localparam logic [3:0] StRWb      = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJump     = 4'd10;
  localparam logic [3:0] StAddiExec = 4'd11;
  localparam logic [3:0] StAddiWb   = 4'd12;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  logic [3:0] state_q, state_d;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  // State register; reset aborts any instruction straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.instr_op)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiExec;
          default:    state_d = StFetch;
        endcase
      end
      // IR is stable here, so the opcode can be re-read to pick the access type.
      StMemAddr:  state_d = (bus.instr_op == OpSw) ? StMemWr : StMemRd;
      StMemRd:    if (bus.mem_ready) state_d = StMemWb;
      StMemWr:    if (bus.mem_ready) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      // Unreachable codes recover like IDLE.
      default:    state_d = StFetch;
    endcase
  end

  // Moore decode of the control lines, gated by mem_ready where a stall applies.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = bus.mem_ready;
        ir_write  = bus.mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (bus.instr_op)
          OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ: illegal_op = 1'b0;
          default:                                 illegal_op = 1'b1;
        endcase
      end
      StMemAddr, StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = bus.mem_ready;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRWb: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.instr_done    = instr_done;
  assign bus.illegal_op    = illegal_op;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle sequences are derived from
// the CPI/stall rules and each cycle's control vector from the state table.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  step_t exp_q[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill, state}
  wire [21:0] obs_vec = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                         bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                         bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                         bus.pc_source, bus.instr_done, bus.illegal_op, bus.state};

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  // Expected control vector for one cycle, straight from the per-state output table.
  function automatic logic [21:0] model_vec(logic [3:0] st, logic rdy, logic [5:0] op);
    logic pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, psrc;
    {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (st)
      4'd1:  begin mrd = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      4'd2:  begin asb = 2'b11; ill = !is_legal(op); end
      4'd3, 4'd11: begin asa = 1; asb = 2'b10; end
      4'd4:  begin mrd = 1; iord = 1; end
      4'd5:  begin m2r = 1; rw = 1; done = 1; end
      4'd6:  begin mwr = 1; iord = 1; done = rdy; end
      4'd7:  begin asa = 1; aop = 2'b10; end
      4'd8:  begin rdst = 1; rw = 1; done = 1; end
      4'd9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      4'd10: begin pcw = 1; psrc = 2'b10; done = 1; end
      4'd12: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill, st};
  endfunction

  function automatic step_t mk(logic [3:0] st, logic rdy, logic [5:0] op);
    step_t s;
    s.st = st; s.rdy = rdy; s.op = op;
    return s;
  endfunction

  // mem_ready in states that ignore it: 1 for directed runs, random otherwise.
  function automatic logic pick(bit rnd);
    return rnd ? logic'($urandom_range(1, 0)) : 1'b1;
  endfunction

  // Append the cycle-by-cycle path of one instruction: fw fetch stalls, mw memory stalls.
  task automatic build_seq(input logic [5:0] op, input int fw, input int mw, input bit rnd);
    for (int k = 0; k < fw; k++) exp_q.push_back(mk(4'd1, 1'b0, op));
    exp_q.push_back(mk(4'd1, 1'b1, op));
    exp_q.push_back(mk(4'd2, pick(rnd), op));
    if (op == OP_R) begin
      exp_q.push_back(mk(4'd7, pick(rnd), op));
      exp_q.push_back(mk(4'd8, pick(rnd), op));
    end else if (op == OP_LW || op == OP_SW) begin
      exp_q.push_back(mk(4'd3, pick(rnd), op));
      for (int k = 0; k < mw; k++) exp_q.push_back(mk((op == OP_LW) ? 4'd4 : 4'd6, 1'b0, op));
      exp_q.push_back(mk((op == OP_LW) ? 4'd4 : 4'd6, 1'b1, op));
      if (op == OP_LW) exp_q.push_back(mk(4'd5, pick(rnd), op));
    end else if (op == OP_BEQ) begin
      exp_q.push_back(mk(4'd9, pick(rnd), op));
    end else if (op == OP_J) begin
      exp_q.push_back(mk(4'd10, pick(rnd), op));
    end else if (op == OP_ADDI) begin
      exp_q.push_back(mk(4'd11, pick(rnd), op));
      exp_q.push_back(mk(4'd12, pick(rnd), op));
    end
  endtask

  // Present one cycle's inputs; FETCH sees a junk opcode since the IR is not yet loaded.
  task automatic drive(input step_t s);
    bus.instr_op = (s.st == 4'd1) ? 6'($urandom) : s.op;
    bus.mem_ready = s.rdy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.instr_op = 6'd0;
    bus.mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs_vec !== 22'd0) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", obs_vec, 22'd0);
    end
    @(posedge clk); #1;
    total++;
    if (obs_vec !== 22'd0) begin
      bad++; $display("FAIL reset_held got=%h exp=%h", obs_vec, 22'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if (obs_vec !== 22'd0) begin
      bad++; $display("FAIL reset_release_idle got=%h exp=%h", obs_vec, 22'd0);
    end
    @(posedge clk); #1;
    total++;
    if (bus.state !== 4'd1) begin
      bad++; $display("FAIL reset_first_fetch got=%0d exp=1", bus.state);
    end
  endtask

  task automatic test_rtype();
    build_seq(OP_R, 0, 0, 1'b0);
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL rtype cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    total++;
    if (bus.state !== 4'd1) begin
      bad++; $display("FAIL rtype_return got=%0d exp=1", bus.state);
    end
  endtask

  task automatic test_lw_wait();
    build_seq(OP_LW, 0, 2, 1'b0);
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL lw_wait cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
  endtask

  task automatic test_sw_fetch_stall();
    int rw_seen = 0;
    build_seq(OP_SW, 1, 0, 1'b0);
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      if (bus.reg_write) rw_seen++;
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL sw_stall cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    total++;
    if (rw_seen !== 0) begin
      bad++; $display("FAIL sw_no_reg_write got=%0d exp=0", rw_seen);
    end
  endtask

  task automatic test_back_to_back();
    int cycles = 0;
    build_seq(OP_BEQ, 0, 0, 1'b0);
    build_seq(OP_J, 0, 0, 1'b0);
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      cycles++;
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL beq_j cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    total++;
    if (cycles !== 6) begin
      bad++; $display("FAIL beq_j_cycles got=%0d exp=6", cycles);
    end
  endtask

  task automatic test_illegal();
    build_seq(6'b111111, 0, 0, 1'b0);
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    total++;
    if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0) begin
      bad++; $display("FAIL illegal_return got=%0d/%b exp=1/0", bus.state, bus.illegal_op);
    end
  endtask

  task automatic test_reset_mid();
    build_seq(OP_R, 0, 0, 1'b0);
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      if (exp_q[i].st != 4'd8) begin
        @(posedge clk); #1;
      end
    end
    exp_q.delete();
    // Now in R_WB, halfway to the next edge: pull reset with no clock.
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.reg_write !== 1'b0 || obs_vec !== 22'd0) begin
      bad++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs_vec, 22'd0);
    end
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    bus.instr_op = OP_ADDI;
    @(posedge clk); #1;
    total++;
    if (bus.state !== 4'd1) begin
      bad++; $display("FAIL reset_mid_fetch got=%0d exp=1", bus.state);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (bus.state !== 4'd11) begin
      bad++; $display("FAIL reset_mid_resume got=%0d exp=11", bus.state);
    end
    // Let addi retire so the next test starts in FETCH.
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] op;
    int legal = 0;
    int done_seen = 0;
    int ill_seen = 0;
    int n_ill = 0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(9, 0) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
        n_ill++;
      end else begin
        op = ops[$urandom_range(5, 0)];
        legal++;
      end
      build_seq(op, $urandom_range(2, 0), $urandom_range(3, 0), 1'b1);
    end
    foreach (exp_q[i]) begin
      drive(exp_q[i]);
      if (bus.instr_done === 1'b1) done_seen++;
      if (bus.illegal_op === 1'b1) ill_seen++;
      total++;
      if (obs_vec !== model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op)) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec,
                 model_vec(exp_q[i].st, exp_q[i].rdy, exp_q[i].op));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    total++;
    if (done_seen !== legal || ill_seen !== n_ill) begin
      bad++;
      $display("FAIL random_pulses got=%0d/%0d exp=%0d/%0d", done_seen, ill_seen, legal, n_ill);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_fetch_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle MIPS control FSM that sequences the shared single-ALU / single-memory datapath over several clock cycles per instruction. It replaces the combinational per-opcode decoder when the datapath is run multicycle: it fetches, decodes, executes and writes back each instruction. It drives every mux select and write enable, and stalls on a memory ready handshake.

## Interface
Parameters: none.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr_op  input  6  opcode field of the instruction register; valid from DECODE onward
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  instruction register load
- mem_to_reg  output  1  write-back data select: 1 = MDR, 0 = ALUOut
- reg_dst  output  1  destination select: 1 = rd, 0 = rt
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  output  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  output  1  one-cycle pulse when the instruction retires
- illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded
- state  output  4  current state encoding, for debug

## Operation
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12. Codes 13–15 are unreachable; they behave like IDLE and go to FETCH.
- Transitions:
  - IDLE → FETCH.
  - FETCH → DECODE when mem_ready; otherwise stay in FETCH.
  - DECODE branches on instr_op:
    - lw/sw → MEM_ADDR
    - R → R_EXEC
    - beq → BRANCH
    - j → JUMP
    - addi → ADDI_EXEC
    - any other opcode → FETCH, with illegal_op = 1
  - MEM_ADDR → MEM_RD for lw, MEM_WR for sw. Opcode is re-read; the IR is stable.
  - MEM_RD → MEM_WB when mem_ready; otherwise stay.
  - MEM_WR → FETCH when mem_ready; otherwise stay.
  - MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP → FETCH.
  - R_EXEC → R_WB; ADDI_EXEC → ADDI_WB.
- Outputs are Moore on state, except mem_ready gating where noted. Every output not listed for a state is 0.
  - FETCH: mem_read=1, alu_src_b=01; pc_write=ir_write=mem_ready.
  - DECODE: alu_src_b=11 (branch target precompute).
  - MEM_ADDR, ADDI_EXEC: alu_src_a=1, alu_src_b=10.
  - MEM_RD: mem_read=1, i_or_d=1.
  - MEM_WR: mem_write=1, i_or_d=1; instr_done=mem_ready.
  - MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1.
  - R_EXEC: alu_src_a=1, alu_op=10.
  - R_WB: reg_dst=1, reg_write=1, instr_done=1.
  - ADDI_WB: reg_write=1, instr_done=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - JUMP: pc_write=1, pc_source=10, instr_done=1.
- mem_read / mem_write stay asserted on every wait cycle. The address select is held stable throughout the wait.
- No other output is X; don't-cares are driven as 0.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE immediately; all outputs 0. The first rising edge after release enters FETCH.
- Reset asserted mid-instruction: abort immediately to IDLE. No partial write-enable may stay high after reset assertion.
- Cycles per instruction at zero wait (FETCH through the retiring state):
  - beq, j: 3
  - R, sw, addi: 4
  - lw: 5
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready is ignored in every other state.
- instr_done and illegal_op never assert in the same cycle. Each is high for exactly one cycle per instruction.
- Next-state logic is registered on the rising edge; outputs change only with state or mem_ready.

## Test plan
- Reset, then release with mem_ready=1 and R-type: state 0→1→2→7→8→1.
  - reg_write=1 and reg_dst=1 only in state 8.
  - instr_done pulses in the 4th cycle after FETCH entry.
- lw with mem_ready low for 2 cycles in MEM_RD: state 3→4→4→4→5.
  - mem_read=1 and i_or_d=1 held through the wait.
  - mem_to_reg=1 and reg_write=1 in state 5.
- sw with mem_ready low for 1 cycle in FETCH: ir_write and pc_write stay 0 on the stall cycle and go to 1 on the ready cycle.
  - mem_write=1 through MEM_WR.
  - No reg_write at any point.
- beq then j back-to-back:
  - BRANCH: pc_write_cond=1, pc_source=01, alu_op=01.
  - JUMP: pc_write=1, pc_source=10.
  - Each takes 3 cycles.
- Opcode 111111: DECODE → FETCH with illegal_op=1 for one cycle. No write enable asserts.
- rst_n pulsed low during R_WB: state=0 and reg_write=0 asynchronously, without waiting for a clock edge. Normal fetch resumes after release.
